// File: rtl/data_bus_rr_arbiter_if.sv
// Data-bus request/response bundle, N lanes wide; lane i uses slice [32*i+:32] etc.
// Handshake: a requester holds req/addr/we/be/wdata stable until it sees gnt in the same cycle as req;
// a response is a single-cycle rvalid (with err/rdata) and responses return strictly in request order.
interface data_bus_rr_arbiter_if #(
    parameter int N = 1
);
    logic [N-1:0]    req;
    logic [32*N-1:0] addr;
    logic [N-1:0]    we;
    logic [4*N-1:0]  be;
    logic [32*N-1:0] wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [N-1:0]    err;
    logic [32*N-1:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/data_bus_rr_arbiter.sv
// Round-robin merge of NMST data-bus masters onto one downstream port, with an in-order
// ID queue that steers each returning response back to the master that issued it.
module data_bus_rr_arbiter #(
    parameter int NMST    = 2,
    parameter int MAX_OUT = 4,
    parameter int IDW     = (NMST > 1) ? $clog2(NMST) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    data_bus_rr_arbiter_if.slave      m_bus,
    data_bus_rr_arbiter_if.master     s_bus,
    output logic [$clog2(MAX_OUT):0]  outstanding,
    output logic                      spurious_rsp
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic [IDW-1:0] id_q [MAX_OUT];
    logic [IDW-1:0] id_d [MAX_OUT];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [OW-1:0]  cnt_q, cnt_d;
    logic           spurious_q, spurious_d;

    logic [IDW-1:0] sel;
    logic [IDW-1:0] head;
    logic           full, empty, s_req_c, hs, pop;

    function automatic logic [PW-1:0] qinc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Lowest offset from ptr_q wins, so scan offsets from the far end down.
    always_comb begin
        int idx;
        sel = ptr_q;
        idx = 0;
        if (lock_q) begin
            sel = lock_id_q;
        end else begin
            for (int k = NMST - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= NMST) idx = idx - NMST;
                if (m_bus.req[idx]) sel = IDW'(idx);
            end
        end
    end

    assign full    = (cnt_q == OW'(MAX_OUT));
    assign empty   = (cnt_q == '0);
    assign head    = id_q[rd_q];
    assign s_req_c = !rst && m_bus.req[sel] && !full;
    assign hs      = s_req_c && s_bus.gnt[0];
    assign pop     = !rst && s_bus.rvalid[0] && !empty;

    always_comb begin
        s_bus.req    = s_req_c;
        s_bus.addr   = '0;
        s_bus.we     = '0;
        s_bus.be     = '0;
        s_bus.wdata  = '0;
        m_bus.gnt    = '0;
        m_bus.rvalid = '0;
        m_bus.err    = '0;
        m_bus.rdata  = '0;
        if (s_req_c) begin
            s_bus.addr       = m_bus.addr[32*int'(sel) +: 32];
            s_bus.we         = m_bus.we[sel];
            s_bus.be         = m_bus.be[4*int'(sel) +: 4];
            s_bus.wdata      = m_bus.wdata[32*int'(sel) +: 32];
            m_bus.gnt[sel]   = s_bus.gnt[0];
        end
        // Responses are only routed while an ID is queued; otherwise they are dropped.
        if (!rst && !empty) begin
            m_bus.rvalid[head]              = s_bus.rvalid[0];
            m_bus.err[head]                 = s_bus.err[0];
            m_bus.rdata[32*int'(head) +: 32] = s_bus.rdata;
        end
    end

    always_comb begin
        int nxt;
        nxt       = int'(sel) + 1;
        if (nxt >= NMST) nxt = 0;
        ptr_d     = hs ? IDW'(nxt) : ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (hs) begin
            lock_d = 1'b0;
        end else if (s_req_c) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
        id_d = id_q;
        if (hs) id_d[wr_q] = sel;
        wr_d = hs  ? qinc(wr_q) : wr_q;
        rd_d = pop ? qinc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (hs && !pop)      cnt_d = cnt_q + OW'(1);
        else if (!hs && pop) cnt_d = cnt_q - OW'(1);
        spurious_d = spurious_q | (s_bus.rvalid[0] & empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
            for (int i = 0; i < MAX_OUT; i++) id_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
            id_q       <= id_d;
        end
    end

    assign outstanding  = cnt_q;
    assign spurious_rsp = spurious_q;
endmodule
